// File: rtl/shr_seq_n_if.sv
// shr_seq_n_if: request/result signal bundle for the sequential right shifter.
// master drives start/din/amt; slave (the shifter) drives the result outputs.
interface shr_seq_n_if #(
  parameter int SIZE  = 4,
  parameter int AMT_W = 3
);
  logic             start;
  logic [SIZE-1:0]  din;
  logic [AMT_W-1:0] amt;
  logic [SIZE-1:0]  dout;
  logic             busy;
  logic             done;
  logic             sout;

  modport master (output start, din, amt, input dout, busy, done, sout);
  modport slave  (input start, din, amt, output dout, busy, done, sout);
endinterface

// File: rtl/shr_seq_n.sv
// shr_seq_n: multi-cycle right shifter, one bit position per clock.
// A start in IDLE/DONE loads din and a saturated shift count; SHIFT moves
// dout right once per cycle; DONE pulses for one cycle with the final result.
// Optional macro SHR_SEQ_ARITH_EN: fill with the operand MSB captured at
// load (arithmetic shift) instead of zero (logical shift).
module shr_seq_n #(
  parameter int SIZE  = 4,
  parameter int AMT_W = 3
) (
  input  logic        clk,
  input  logic        rst,
  shr_seq_n_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [SIZE-1:0]  dout_q;
  logic [AMT_W-1:0] cnt;
  logic             sout_q;
  logic             load;
  logic [AMT_W-1:0] eff_amt;
  logic             fill;

  // Requested count saturated to SIZE so oversize amounts clear to fill.
  assign eff_amt = (bus.amt > AMT_W'(SIZE)) ? AMT_W'(SIZE) : bus.amt;

`ifdef SHR_SEQ_ARITH_EN
  // Sign bit captured at load; dout[SIZE-1] itself is reused as the fill
  // source after the first shift, so a separate copy keeps it stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       fill <= 1'b0;
    else if (load) fill <= bus.din[SIZE-1];
  end
`else
  assign fill = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state and load decision; start is only honoured in IDLE or DONE.
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          load     = 1'b1;
          state_nx = (eff_amt != '0) ? SHIFT : DONE;
        end else begin
          state_nx = IDLE;
        end
      end
      SHIFT: begin
        // Counter reaches zero on this edge.
        if (cnt == AMT_W'(1)) state_nx = DONE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: load operand, or shift one place while in SHIFT; hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q <= '0;
      cnt    <= '0;
      sout_q <= 1'b0;
    end else if (load) begin
      dout_q <= bus.din;
      cnt    <= eff_amt;
      sout_q <= 1'b0;
    end else if (state == SHIFT) begin
      dout_q <= {fill, dout_q[SIZE-1:1]};
      sout_q <= dout_q[0];
      cnt    <= cnt - AMT_W'(1);
    end
  end

  assign bus.dout = dout_q;
  assign bus.sout = sout_q;
  assign bus.busy = (state == SHIFT);
  assign bus.done = (state == DONE);

endmodule

// File: tb/tb_shr_seq_n.sv
// tb_shr_seq_n: directed stimulus with a result scoreboard for shr_seq_n.
module tb_shr_seq_n;
  localparam int SIZE  = 4;
  localparam int AMT_W = 3;

  typedef struct {
    logic [SIZE-1:0] dout;
    logic            sout;
    int              n;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   busy_cnt = 0;
  exp_t sb[$];

  shr_seq_n_if #(.SIZE(SIZE), .AMT_W(AMT_W)) bus ();

  shr_seq_n #(.SIZE(SIZE), .AMT_W(AMT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference result computed arithmetically, not cycle by cycle.
  function automatic exp_t model(input logic [SIZE-1:0] d, input logic [AMT_W-1:0] a);
    exp_t r;
    int   n;
    n = (int'(a) > SIZE) ? SIZE : int'(a);
    r.n = n;
`ifdef SHR_SEQ_ARITH_EN
    r.dout = SIZE'($signed(d) >>> n);
`else
    r.dout = d >> n;
`endif
    r.sout = (n == 0) ? 1'b0 : d[n-1];
    return r;
  endfunction

  // Result monitor: counts busy cycles, pops and compares on each done.
  always @(negedge clk) begin
    if (rst) begin
      busy_cnt = 0;
    end else begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'(bus.done), 32'(0));
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("dout", 32'(bus.dout), 32'(e.dout));
          check("sout", 32'(bus.sout), 32'(e.sout));
          check("busy_cycles", 32'(busy_cnt), 32'(e.n));
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic drive_start(input logic [SIZE-1:0] d, input logic [AMT_W-1:0] a);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.din   = d;
    bus.amt   = a;
    sb.push_back(model(d, a));
  endtask

  task automatic wait_drain(input string tag);
    int i;
    i = 0;
    while (sb.size() != 0 && i < 40) begin
      @(posedge clk);
      i++;
    end
    check(tag, 32'(sb.size()), 32'(0));
    sb.delete();
  endtask

  task automatic run_op(input logic [SIZE-1:0] d, input logic [AMT_W-1:0] a, input string tag);
    drive_start(d, a);
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_drain(tag);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.din   = '0;
    bus.amt   = '0;
    #12;
    check("rst_dout", 32'(bus.dout), 32'(0));
    check("rst_busy", 32'(bus.busy), 32'(0));
    check("rst_done", 32'(bus.done), 32'(0));
    check("rst_sout", 32'(bus.sout), 32'(0));
    @(posedge clk); #1 rst = 1'b0;

    // Basic shift, then confirm result holds while idle.
    run_op(4'b1011, 3'd2, "op_1011_a2");
    repeat (2) @(posedge clk);
    #1;
    check("hold_dout", 32'(bus.dout), 32'(model(4'b1011, 3'd2).dout));
    check("hold_busy", 32'(bus.busy), 32'(0));

    // Zero count: straight to DONE.
    run_op(4'b1001, 3'd0, "op_1001_a0");
    // Oversize count saturates to SIZE.
    run_op(4'b1111, 3'd7, "op_1111_a7");
    run_op(4'b0110, 3'd4, "op_0110_a4");

    // Second start during SHIFT is ignored.
    drive_start(4'b1100, 3'd3);
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.din   = 4'b0001;
    bus.amt   = 3'd1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_drain("ignored_start");

    // Asynchronous reset mid-operation aborts with no done.
    drive_start(4'b1101, 3'd3);
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    sb.delete();
    check("abort_dout", 32'(bus.dout), 32'(0));
    check("abort_busy", 32'(bus.busy), 32'(0));
    check("abort_done", 32'(bus.done), 32'(0));
    check("abort_sout", 32'(bus.sout), 32'(0));
    @(posedge clk); #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    run_op(4'b0100, 3'd1, "after_rst");

    // Start held high across DONE: back-to-back operations.
    drive_start(4'b1010, 3'd2);
    @(posedge clk); #1;
    bus.din = 4'b0111;
    bus.amt = 3'd1;
    sb.push_back(model(4'b0111, 3'd1));
    begin
      int i;
      i = 0;
      while (!bus.done && i < 20) begin
        @(negedge clk);
        i++;
      end
      check("b2b_first_done", 32'(bus.done), 32'(1));
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("b2b_second_busy", 32'(bus.busy), 32'(1));
    wait_drain("b2b");

    // A few random operands.
    for (int k = 0; k < 6; k++) begin
      run_op(SIZE'($urandom), AMT_W'($urandom), "rand_op");
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/shr_seq_n.md
SHR_SEQ_N -- requirements
Module: shr_seq_n

Interface
REQ-001 SHALL provide parameter SIZE, default 4, data width in bits (>= 2).
REQ-002 SHALL provide parameter AMT_W, default 3, shift-amount width; must satisfy 2**AMT_W > SIZE.
REQ-003 SHALL provide port clk  input  1  single rising-edge clock for all state.
REQ-004 SHALL provide port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL provide port start  input  1  request to load din and begin shifting.
REQ-006 SHALL provide port din  input  SIZE  operand captured on an accepted start.
REQ-007 SHALL provide port amt  input  AMT_W  requested right-shift count captured on an accepted start.
REQ-008 SHALL provide port dout  output  SIZE  registered shift-register contents.
REQ-009 SHALL provide port busy  output  1  high while shifts remain.
REQ-010 SHALL provide port done  output  1  one-cycle pulse when the result is final.
REQ-011 SHALL provide port sout  output  1  last bit shifted out of dout[0].

Function
REQ-012 SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-013 In IDLE or DONE, start=1 SHALL be accepted: dout<=din, counter<=min(amt,SIZE), sout<=0.
REQ-014 On acceptance the FSM SHALL go to SHIFT if the effective count is nonzero, otherwise to DONE.
REQ-015 In SHIFT, each clock SHALL perform one logical right shift: dout<={fill,dout[SIZE-1:1]}, sout<=dout[0], counter decrements by 1.
REQ-016 The FSM SHALL leave SHIFT for DONE on the clock edge where the counter reaches 0.
REQ-017 In DONE, done SHALL be 1 for exactly one cycle; the FSM returns to IDLE unless start=1, in which case it accepts it per REQ-013.
REQ-018 busy SHALL be 1 exactly while the state is SHIFT.
REQ-019 Latency: with start sampled at edge 0 and effective count N, busy SHALL be high for cycles 1..N and done SHALL be high in cycle N+1.
REQ-020 start SHALL be ignored while in SHIFT; din and amt SHALL have no effect outside acceptance.
REQ-021 amt > SIZE SHALL saturate to SIZE, producing dout = all fill bits.
REQ-022 dout and sout SHALL hold their values in IDLE and DONE until the next acceptance.
REQ-023 Shifting SHALL never wrap: no bit of dout re-enters at the MSB.

Reset
REQ-024 rst=1 SHALL immediately force state=IDLE, dout=0, counter=0, sout=0, busy=0, done=0, independent of clk.
REQ-025 rst asserted mid-SHIFT SHALL abort the operation with no done pulse; after release, the first start is accepted normally.

Configuration
REQ-026 Macro SHR_SEQ_ARITH_EN: when defined, fill SHALL equal the dout[SIZE-1] value captured at acceptance (arithmetic shift, sign replicated).
REQ-027 Without SHR_SEQ_ARITH_EN, fill SHALL be 0 (logical shift); all other behaviour is identical.

Verification
REQ-028 SIZE=4; start, din=4'b1011, amt=2 -> busy in cycles 1-2, done in cycle 3, dout=4'b0010, sout=1.
REQ-029 start, din=4'b1001, amt=0 -> busy never high, done in cycle 1, dout=4'b1001, sout=0.
REQ-030 start, din=4'b1111, amt=7 -> 4 busy cycles, dout=4'b0000 (4'b1111 with SHR_SEQ_ARITH_EN), done in cycle 5.
REQ-031 start, amt=3, then start pulsed again in cycle 2 with din=4'b0001 -> second start ignored, result reflects only the first operand.
REQ-032 rst pulsed in cycle 2 of an amt=3 operation -> outputs zero immediately, no done pulse; a following start, din=4'b0100, amt=1 -> dout=4'b0010.
REQ-033 start held high across DONE -> back-to-back operation: second load occurs in the first operation's done cycle, with a single done pulse per operation.
